decoder_3to8: RTL and testbench
===============================

// Module: decoder_3to8
// PURPOSE
//   3-to-8 one-hot decoder with enable. Drives a zero-latency combinational one-hot
//   select bus for chip-select or row-select fan-out.
//   Also provides a registered copy for timing-critical consumers, plus a sticky
//   record of the last enabled select.
//   Combinational path is independent of clk and rst.
// PARAMETERS
//   ACTIVE_LOW   0   1: invert Out and Out_r; disabled/reset level becomes 8'hFF
// PORTS
//   clk     in   1   single clock; rising edge
//   rst     in   1   asynchronous, active-high reset
//   E       in   1   enable; 0 forces all outputs inactive
//   In      in   3   binary select, 0..7
//   Out     out  8   combinational one-hot decode
//   Out_r   out  8   Out registered, 1-cycle latency
//   sel_q   out  3   In captured on last clk edge with E=1
//   seen_q  out  1   set on first clk edge with E=1; sticky until rst
// BEHAVIOUR
//   Combinational decode (ACTIVE_LOW=0):
//   - Out = E ? (8'b1 << In) : 8'h00
//   - exactly one bit set when E=1; bit index == In (In=3'b000 -> bit0, 3'b111 -> bit7)
//   - settles within the same delta as E/In change; no clock required
//   - unaffected by rst
//   ACTIVE_LOW=1: Out = ~(above); Out_r inverted likewise; reset/disabled level 8'hFF.
//   Registered path, on posedge clk:
//   - Out_r <= Out
//   - if E: sel_q <= In, seen_q <= 1
//   - if !E: sel_q and seen_q hold
//   Reset, rst=1, asynchronous (immediate, no clock edge needed):
//   - Out_r = inactive level (8'h00, or 8'hFF if ACTIVE_LOW)
//   - sel_q = 3'b000, seen_q = 0
//   - registers held while rst=1
//   - first update on the first posedge after rst deasserts
//   Boundaries:
//   - E toggling without a clock edge changes Out only; registers untouched
//   - rst asserted mid-stream clears registers; Out keeps tracking E/In
//   - X/Z on In or E: outputs are don't-care, not checked
//   No state machine, no handshake; In wraps naturally over 3 bits.
// TESTING
//   1. E=0, In=000 -> Out=8'h00; every In value with E=0 -> Out=8'h00
//   2. E=1, sweep In 000..111 at 10-unit steps -> Out = 01,02,04,08,10,20,40,80
//      (one-hot, index==In)
//   3. clk running, E=1, In=101 -> Out=8'h20 same delta; Out_r=8'h20 after next
//      posedge; sel_q=5, seen_q=1
//   4. rst=1 mid-sweep (E=1, In=011) -> Out_r=00, sel_q=0, seen_q=0 immediately;
//      Out stays 8'h08
//   5. E=1 In=110 clocked, then E=0 In=001 clocked -> Out=00, Out_r=00; sel_q=6
//      held, seen_q=1 held
//   6. ACTIVE_LOW=1: E=1, In=010 -> Out=8'hFB; E=0 -> Out=8'hFF; after rst,
//      Out_r=8'hFF

Source files
------------

// File: rtl/decoder_3to8_if.sv
// Decoder select/decode bundle.
//   E       enable (master -> slave)
//   In      3-bit binary select (master -> slave)
//   Out     combinational one-hot decode (slave -> master)
//   Out_r   registered copy of Out, 1-cycle latency (slave -> master)
//   sel_q   In captured on the last enabled clock edge (slave -> master)
//   seen_q  sticky flag, set by the first enabled clock edge (slave -> master)
interface decoder_3to8_if;
  logic       E;
  logic [2:0] In;
  logic [7:0] Out;
  logic [7:0] Out_r;
  logic [2:0] sel_q;
  logic       seen_q;

  modport master (
    output E,
    output In,
    input  Out,
    input  Out_r,
    input  sel_q,
    input  seen_q
  );

  modport slave (
    input  E,
    input  In,
    output Out,
    output Out_r,
    output sel_q,
    output seen_q
  );
endinterface

// File: rtl/decoder_3to8.sv
// 3-to-8 one-hot decoder with enable.
// Drives a zero-latency combinational one-hot select bus, a registered copy of it,
// and a sticky record of the last enabled select.
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (clears registered outputs only)
//   bus   decoder_3to8_if.slave: E, In in; Out, Out_r, sel_q, seen_q out
// ACTIVE_LOW=1 inverts Out and Out_r; their inactive/reset level becomes 8'hFF.
module decoder_3to8 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic            clk,
  input logic            rst,
  decoder_3to8_if.slave  bus
);

  localparam logic [7:0] Inactive = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] onehot;
  logic [7:0] out_comb;
  logic [7:0] out_r_q;
  logic [2:0] sel_d, sel_q;
  logic       seen_d, seen_q;

  // Pure combinational path; deliberately independent of clk and rst.
  always_comb begin
    onehot = 8'h00;
    if (bus.E) begin
      onehot[bus.In] = 1'b1;
    end
    out_comb = ACTIVE_LOW ? ~onehot : onehot;
  end

  always_comb begin
    sel_d  = sel_q;
    seen_d = seen_q;
    if (bus.E) begin
      sel_d  = bus.In;
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r_q <= Inactive;
      sel_q   <= 3'b000;
      seen_q  <= 1'b0;
    end else begin
      out_r_q <= out_comb;
      sel_q   <= sel_d;
      seen_q  <= seen_d;
    end
  end

  assign bus.Out    = out_comb;
  assign bus.Out_r  = out_r_q;
  assign bus.sel_q  = sel_q;
  assign bus.seen_q = seen_q;

endmodule

// File: tb/tb_decoder_3to8.sv
module tb_decoder_3to8;

  typedef struct {
    logic       e;
    logic [2:0] in;
    logic [7:0] out_r;   // positive-logic expectation
    logic [2:0] sel;
    logic       seen;
  } exp_t;

  logic clk;
  logic rst;

  decoder_3to8_if bus0 ();
  decoder_3to8_if bus1 ();

  decoder_3to8 #(.ACTIVE_LOW(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  decoder_3to8 #(.ACTIVE_LOW(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t reg_q[$];   // checked after the next rising edge
  exp_t imm_q[$];   // checked immediately, no clock edge involved
  event imm_ev;

  // Reference model state (positive logic).
  logic [7:0] m_out_r;
  logic [2:0] m_sel;
  logic       m_seen;

  function automatic logic [7:0] decode(input logic e, input logic [2:0] in);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = e && (i == int'(in));
    return r;
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input exp_t x);
    chk8({tag, " out"},     bus0.Out,             decode(x.e, x.in));
    chk8({tag, " out_r"},   bus0.Out_r,           x.out_r);
    chk8({tag, " sel"},     {5'd0, bus0.sel_q},   {5'd0, x.sel});
    chk8({tag, " seen"},    {7'd0, bus0.seen_q},  {7'd0, x.seen});
    chk8({tag, " al out"},  bus1.Out,             ~decode(x.e, x.in));
    chk8({tag, " al out_r"}, bus1.Out_r,          ~x.out_r);
    chk8({tag, " al sel"},  {5'd0, bus1.sel_q},   {5'd0, x.sel});
    chk8({tag, " al seen"}, {7'd0, bus1.seen_q},  {7'd0, x.seen});
  endtask

  // Registered monitor: one entry per rising edge, sampled away from the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (reg_q.size() > 0) begin
        x = reg_q.pop_front();
        compare("reg", x);
      end
    end
  end

  // Immediate monitor: combinational and asynchronous-reset behaviour.
  initial begin
    exp_t x;
    forever begin
      @(imm_ev);
      while (imm_q.size() > 0) begin
        x = imm_q.pop_front();
        compare("imm", x);
      end
    end
  end

  task automatic drive(input logic e, input logic [2:0] in);
    bus0.E = e; bus0.In = in;
    bus1.E = e; bus1.In = in;
  endtask

  task automatic push_imm(input logic e, input logic [2:0] in);
    exp_t x;
    x.e = e; x.in = in; x.out_r = m_out_r; x.sel = m_sel; x.seen = m_seen;
    imm_q.push_back(x);
    -> imm_ev;
  endtask

  // One clock cycle: optional glitch on E/In well clear of any edge, then the
  // real inputs, an immediate check, and the expectation for the next edge.
  task automatic step(input logic rst_v, input logic e, input logic [2:0] in,
                      input logic glitch, input logic ge, input logic [2:0] gin);
    exp_t x;
    @(negedge clk);
    if (glitch) begin
      drive(ge, gin);
      #1;
      push_imm(ge, gin);
      #1;
    end
    rst = rst_v;
    drive(e, in);
    #1;
    if (rst_v) begin
      m_out_r = 8'h00; m_sel = 3'd0; m_seen = 1'b0;
    end
    push_imm(e, in);
    if (!rst_v) begin
      m_out_r = decode(e, in);
      if (e) begin
        m_sel  = in;
        m_seen = 1'b1;
      end
    end
    x.e = e; x.in = in; x.out_r = m_out_r; x.sel = m_sel; x.seen = m_seen;
    reg_q.push_back(x);
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    drive(1'b0, 3'd0);
    m_out_r = 8'h00; m_sel = 3'd0; m_seen = 1'b0;
    #3;
    push_imm(1'b0, 3'd0);

    // Disabled: every select decodes to inactive.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'(i), 1'b0, 1'b0, 3'd0);
    // Enabled sweep.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'(i), 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0);
    // Reset mid-stream while enabled.
    step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0);
    // Enabled then disabled: sel/seen hold.
    step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0);
    // E toggles between edges: only Out may move.
    step(1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 3'd7);

    for (int n = 0; n < 200; n++) begin
      step(($urandom_range(15) == 0), 1'($urandom), 3'($urandom),
           ($urandom_range(3) == 0), 1'($urandom), 3'($urandom));
    end
    step(1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 3'd0);

    budget = 0;
    while ((reg_q.size() > 0 || imm_q.size() > 0) && budget < 10) begin
      @(posedge clk);
      #3;
      budget++;
    end
    checks++;
    if (reg_q.size() > 0 || imm_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", reg_q.size() + imm_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
